sqrt2_host: RTL and testbench

- Bus-side initiator for the sqrt2 float16 square-root unit; it is the other end of the IO_DATA/ENABLE/RESULT protocol.
- Accepts operands on a valid/ready request port and drives each operand onto the shared tri-state IO_DATA bus with ENABLE.
- Releases the bus, waits for RESULT, then captures the result word and the NaN/±Inf flags.
- Returns the result on a valid/ready response port. Sits between a test sequencer or CPU-side register block and the sqrt2 instance.

---
 rtl/sqrt2_bus_pkg.sv | 28 ++
 rtl/sqrt2_bus_driver.sv | 42 ++++
 rtl/sqrt2_host.sv | 159 +++++++++++++++
 tb/tb_sqrt2_host.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt2_bus_pkg.sv
// Shared types and float16 constants for the sqrt2 bus host.
// No logic here: types, constants and the response record only.
package sqrt2_bus_pkg;

    localparam int F16_W = 16;

    localparam logic [F16_W-1:0] F16_PINF = 16'h7C00;
    localparam logic [F16_W-1:0] F16_NINF = 16'hFC00;
    localparam logic [F16_W-1:0] F16_QNAN = 16'h7E00;
    localparam logic [F16_W-1:0] F16_ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [F16_W-1:0] data;
        logic             nan;
        logic             pinf;
        logic             ninf;
        logic             timeout;
    } rsp_t;

endpackage

// File: rtl/sqrt2_bus_driver.sv
// Registered tri-state driver for IO_DATA: operand register plus output enable.
// One-cycle latency from load/drop to the pad; no backpressure, the FSM owns sequencing.
module sqrt2_bus_driver #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          drop,
    input  logic [DW-1:0] load_dat,
    inout  wire  [DW-1:0] io_data,
    output logic          oe
);

    logic          oe_q, oe_d;
    logic [DW-1:0] dat_q, dat_d;

    always_comb begin
        oe_d  = oe_q;
        dat_d = dat_q;
        if (load) begin
            oe_d  = 1'b1;
            dat_d = load_dat;
        end else if (drop) begin
            oe_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_q  <= 1'b0;
            dat_q <= '0;
        end else begin
            oe_q  <= oe_d;
            dat_q <= dat_d;
        end
    end

    assign io_data = oe_q ? dat_q : 'z;
    assign oe      = oe_q;

endmodule

// File: rtl/sqrt2_host.sv
// Bus-side initiator for sqrt2: drives an operand, waits for RESULT (or times out), returns it.
// One transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module sqrt2_host
    import sqrt2_bus_pkg::*;
#(
    parameter int DW             = 16,
    parameter int DRIVE_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_nan,
    output logic          rsp_pinf,
    output logic          rsp_ninf,
    output logic          rsp_timeout,
    output logic          busy,
    inout  wire  [DW-1:0] IO_DATA,
    output logic          ENABLE,
    input  logic          RESULT,
    input  logic          IS_NAN,
    input  logic          IS_PINF,
    input  logic          IS_NINF
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DRV_LAST = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          enable_q, enable_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;
    rsp_t          rsp_q, rsp_d;
    logic          drv_load, drv_drop;
    logic          drv_oe;

    sqrt2_bus_driver #(.DW(DW)) u_drv (
        .clk      (CLK),
        .rst      (RST),
        .load     (drv_load),
        .drop     (drv_drop),
        .load_dat (req_data),
        .io_data  (IO_DATA),
        .oe       (drv_oe)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enable_d    = enable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        drv_load    = 1'b0;
        drv_drop    = 1'b0;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    drv_load = 1'b1;
                    enable_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // RESULT here means sqrt2 is fighting us for the bus: back off at once.
                if (RESULT) drv_drop = 1'b1;
                if (cnt_q == DRV_LAST) begin
                    drv_drop = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT: begin
                if (RESULT) begin
                    rsp_d       = '{data: IO_DATA, nan: IS_NAN, pinf: IS_PINF,
                                    ninf: IS_NINF, timeout: 1'b0};
                    rsp_valid_d = 1'b1;
                    enable_d    = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_d       = '{data: '0, nan: 1'b0, pinf: 1'b0,
                                    ninf: 1'b0, timeout: 1'b1};
                    rsp_valid_d = 1'b1;
                    enable_d    = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                enable_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            enable_q    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enable_q    <= enable_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_q.data;
    assign rsp_nan     = rsp_q.nan;
    assign rsp_pinf    = rsp_q.pinf;
    assign rsp_ninf    = rsp_q.ninf;
    assign rsp_timeout = rsp_q.timeout;
    assign busy        = busy_q;
    assign ENABLE      = enable_q;

endmodule

// File: tb/tb_sqrt2_host.sv
// Scoreboard bench for sqrt2_host with a behavioural sqrt2 stub on the shared bus.
module tb_sqrt2_host;
    import sqrt2_bus_pkg::*;

    localparam int DRV = 2;
    localparam int TO  = 20;
    localparam int GAP = 2;

    logic        CLK, RST;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_data, rsp_data;
    logic        rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout, busy;
    logic        ENABLE, RESULT, IS_NAN, IS_PINF, IS_NINF;
    wire  [15:0] io_data;

    int n_checks = 0;
    int n_err    = 0;
    rsp_t sb[$];

    sqrt2_host #(.DW(16), .DRIVE_CYCLES(DRV), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_nan(rsp_nan), .rsp_pinf(rsp_pinf), .rsp_ninf(rsp_ninf),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .IO_DATA(io_data), .ENABLE(ENABLE), .RESULT(RESULT),
        .IS_NAN(IS_NAN), .IS_PINF(IS_PINF), .IS_NINF(IS_NINF)
    );

    wire host_oe = dut.u_drv.oe_q;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // sqrt2 stand-in: samples the operand on the first ENABLE cycle, answers a few cycles later.
    logic        stub_respond;
    logic        s_busy, s_res;
    logic [15:0] s_op;
    int          s_cnt;
    logic [18:0] s_out;

    function automatic logic [18:0] stub_sqrt(input logic [15:0] x);
        case (x)
            16'h4400: return {16'h4000, 3'b000};
            16'h7C00: return {16'h7C00, 3'b010};
            16'hBC00: return {16'h7E00, 3'b100};
            16'hFC00: return {16'h7E00, 3'b100};
            16'h3C00: return {16'h3C00, 3'b000};
            default:  return {16'h7E00, 3'b100};
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            s_busy <= 1'b0; s_res <= 1'b0; s_cnt <= 0; s_op <= '0;
        end else if (!s_busy && ENABLE) begin
            s_busy <= 1'b1; s_op <= io_data; s_cnt <= 0;
        end else if (s_busy) begin
            if (!ENABLE) begin
                s_busy <= 1'b0; s_res <= 1'b0;
            end else if (s_cnt == 3 && stub_respond) begin
                s_res <= 1'b1;
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end
    end

    assign s_out   = stub_sqrt(s_op);
    assign io_data = s_res ? s_out[18:3] : 16'hzzzz;
    assign RESULT  = s_res;
    assign IS_NAN  = s_res & s_out[2];
    assign IS_PINF = s_res & s_out[1];
    assign IS_NINF = s_res & s_out[0];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: bus integrity every cycle, scoreboard pop on each response handshake.
    int   cyc = 0, t_wait = 0, rsp_lat = 0, drv_win = 0, low_len = 0;
    logic en_prev = 1'b0, oe_prev = 1'b0, rv_prev = 1'b0, seen_fall = 1'b0, gap_chk = 1'b0;

    always @(negedge CLK) begin
        logic has_x;
        rsp_t e;
        cyc++;
        chk("bus_contention", {31'd0, host_oe & RESULT}, 32'd0);
        if (host_oe || RESULT) begin
            chk("io_data_driven_known", {31'd0, $isunknown(io_data)}, 32'd0);
        end else begin
            has_x = 1'b0;
            for (int i = 0; i < 16; i++) if (io_data[i] === 1'bx) has_x = 1'b1;
            chk("io_data_no_x", {31'd0, has_x}, 32'd0);
        end

        if (ENABLE && !en_prev) drv_win = 0;
        if (host_oe) drv_win++;
        if (oe_prev && !host_oe) t_wait = cyc;
        if (rsp_valid && !rv_prev) rsp_lat = cyc - t_wait;

        // ENABLE low run between back-to-back requests spans RESP, GAP and the IDLE accept cycle.
        if (!gap_chk) begin
            seen_fall = 1'b0; low_len = 0;
        end else if (!ENABLE) begin
            if (en_prev) seen_fall = 1'b1;
            low_len++;
        end else begin
            if (!en_prev && seen_fall) chk("enable_low_gap", low_len, GAP + 2);
            low_len = 0;
        end

        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                chk("rsp_flags", {28'd0, rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout},
                    {28'd0, e.nan, e.pinf, e.ninf, e.timeout});
                chk("enable_low_at_rsp", {31'd0, ENABLE}, 32'd0);
                chk("drive_window", drv_win, DRV);
                if (e.timeout) chk("timeout_latency", rsp_lat, TO);
            end
        end
        en_prev = ENABLE; oe_prev = host_oe; rv_prev = rsp_valid;
    end

    task automatic send(input logic [15:0] op, input rsp_t exp, input bit push);
        bit done = 1'b0;
        if (push) sb.push_back(exp);
        req_valid = 1'b1;
        req_data  = op;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (req_ready) begin
                @(posedge CLK); #1;
                done = 1'b1;
            end
        end
        req_valid = 1'b0;
        if (!done) chk("req_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 300) begin
            @(posedge CLK); #1; i++;
        end
        chk("drain_empty", sb.size(), 0);
        while (busy && i < 300) begin
            @(posedge CLK); #1; i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        rsp_t r_4000 = '{data: 16'h4000, nan: 1'b0, pinf: 1'b0, ninf: 1'b0, timeout: 1'b0};
        rsp_t r_pinf = '{data: 16'h7C00, nan: 1'b0, pinf: 1'b1, ninf: 1'b0, timeout: 1'b0};
        rsp_t r_nan  = '{data: 16'h7E00, nan: 1'b1, pinf: 1'b0, ninf: 1'b0, timeout: 1'b0};
        rsp_t r_to   = '{data: 16'h0000, nan: 1'b0, pinf: 1'b0, ninf: 1'b0, timeout: 1'b1};
        rsp_t r_one  = '{data: 16'h3C00, nan: 1'b0, pinf: 1'b0, ninf: 1'b0, timeout: 1'b0};

        RST = 1'b1; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b1; stub_respond = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_enable", {31'd0, ENABLE}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_flags", {28'd0, rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_oe", {31'd0, host_oe}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Normal operand followed by back-to-back specials with rsp_ready tied high.
        gap_chk = 1'b1;
        send(16'h4400, r_4000, 1'b1);
        send(16'h7C00, r_pinf, 1'b1);
        send(16'hBC00, r_nan,  1'b1);
        send(16'hFC00, r_nan,  1'b1);
        drain();
        gap_chk = 1'b0;

        // Stub never answers: expect a timeout response.
        stub_respond = 1'b0;
        send(16'h4400, r_to, 1'b1);
        drain();
        stub_respond = 1'b1;

        // Backpressure: hold rsp_ready low for 20 cycles once the response is up.
        rsp_ready = 1'b0;
        send(F16_ONE, r_one, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge CLK); #1;
            seen = rsp_valid;
        end
        chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {16'd0, rsp_data}, 32'h3C00);
            chk("bp_enable", {31'd0, ENABLE}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            k++;
            if (req_ready) break;
        end
        chk("bp_gap_to_idle", k, GAP + 1);
        drain();

        // Reset in the middle of WAIT.
        stub_respond = 1'b0;
        send(16'h4400, r_4000, 1'b0);
        for (int i = 0; i < 20 && host_oe; i++) begin
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        chk("midwait_enable_before", {31'd0, ENABLE}, 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("midwait_rst_enable", {31'd0, ENABLE}, 32'd0);
        chk("midwait_rst_oe", {31'd0, host_oe}, 32'd0);
        chk("midwait_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midwait_rst_req_ready", {31'd0, req_ready}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midwait_req_ready", {31'd0, req_ready}, 32'd1);
        stub_respond = 1'b1;

        send(16'h4400, r_4000, 1'b1);
        drain();
        repeat (3) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
